// File: rtl/xor_share_arbiter_pkg.sv
// Shared types and constants for the two-requester XOR arbiter.
//   XOR_W        : width of the gate-level XOR datapath
//   req_id_t     : requester identifier (0 or 1)
//   slot_state_t : occupancy of the single registered result slot
package xor_arb_pkg;

    localparam int XOR_W = 64;

    typedef logic req_id_t;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

endpackage

// File: rtl/xor_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   valid [1:0] : request lines
//   ptr         : requester holding priority when both request
//   grant       : selected requester (0 when nobody requests)
//   any         : at least one request present
module rr_arb2
    import xor_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    ptr,
    output req_id_t    grant,
    output logic       any
);

    // NOTE: every output of a combinational block gets a default first so
    // no path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        grant = 1'b0;
        any   = |valid;
        if (valid == 2'b11) begin
            grant = ptr;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/xor_share_arbiter_xor64.sv
// Gate-level bitwise XOR datapath of fixed width XOR_W.
//   a, b : operands
//   y    : a ^ b
module xor64_gate
    import xor_arb_pkg::*;
(
    input  logic [XOR_W-1:0] a,
    input  logic [XOR_W-1:0] b,
    output logic [XOR_W-1:0] y
);

    for (genvar i = 0; i < XOR_W; i++) begin : g_bit
        xor u_xor (y[i], a[i], b[i]);
    end

endmodule

// File: rtl/xor_share_arbiter.sv
// Shares one XOR datapath between two valid/ready requesters using
// round-robin arbitration; the result sits in one registered slot tagged
// with the owning requester id.
//   clk, reset          : clock, synchronous active-high reset
//   req0_* / req1_*     : requester valid, operands A/B, ready (accept strobe)
//   res_valid/id/out    : result slot contents, res_ready drains it
//   grant_cnt0/1        : wrapping counts of accepted transfers per requester
module xor_share_arbiter
    import xor_arb_pkg::*;
#(
    parameter int WIDTH = XOR_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_id,
    output logic [WIDTH-1:0] res_out,
    input  logic             res_ready,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    slot_state_t      state_q;
    slot_state_t      state_d;
    req_id_t          rr_ptr;
    req_id_t          grant;
    logic             any_valid;
    logic             slot_free;
    logic             transfer;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] xor_y;

    assign res_valid = (state_q == SLOT_FULL);
    // A full slot that is being drained this cycle can be refilled at once.
    assign slot_free = !res_valid || res_ready;

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (any_valid)
    );

    // Readys follow the grant, not the requester's own valid; reset holds
    // both low so nothing is accepted while the slot is being cleared.
    assign req0_ready = !reset && slot_free && (grant == 1'b0);
    assign req1_ready = !reset && slot_free && (grant == 1'b1);
    assign transfer   = !reset && slot_free && any_valid;

    // Single shared datapath: operands are steered by the grant.
    assign op_a = grant ? req1_a : req0_a;
    assign op_b = grant ? req1_b : req0_b;

    xor64_gate u_xor (
        .a (op_a),
        .b (op_b),
        .y (xor_y)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (transfer) state_d = SLOT_FULL;
            SLOT_FULL:  if (res_ready && !transfer) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SLOT_EMPTY;
            res_id     <= 1'b0;
            res_out    <= '0;
            rr_ptr     <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            state_q <= state_d;
            if (transfer) begin
                res_out <= xor_y;
                res_id  <= grant;
                rr_ptr  <= ~grant;
                if (grant == 1'b0) begin
                    grant_cnt0 <= grant_cnt0 + 1'b1;
                end else begin
                    grant_cnt1 <= grant_cnt1 + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_share_arbiter.sv
module tb_xor_share_arbiter;

    localparam int WIDTH = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             res_valid, res_id, res_ready;
    logic [WIDTH-1:0] res_out;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    xor_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_out    (res_out),
        .res_ready  (res_ready),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        res_ready  = 1'b1;

        // 1: reset held two cycles with both valid
        tick();
        settle();
        check("rst_ready0_c1", {63'd0, req0_ready}, 64'd0);
        check("rst_ready1_c1", {63'd0, req1_ready}, 64'd0);
        tick();
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_res_id", {63'd0, res_id}, 64'd0);
        check("rst_res_out", res_out, 64'd0);
        check("rst_cnt0", {60'd0, grant_cnt0}, 64'd0);
        check("rst_cnt1", {60'd0, grant_cnt1}, 64'd0);
        check("rst_ready0_c2", {63'd0, req0_ready}, 64'd0);
        check("rst_ready1_c2", {63'd0, req1_ready}, 64'd0);
        reset = 1'b0;
        settle();
        check("first_grant_ready0", {63'd0, req0_ready}, 64'd1);
        check("first_grant_ready1", {63'd0, req1_ready}, 64'd0);

        // 2: req0 alone
        req1_valid = 1'b0;
        req0_a = 64'hAAAA_AAAA_AAAA_AAAA;
        req0_b = 64'h5555_5555_5555_5555;
        settle();
        check("solo_ready0", {63'd0, req0_ready}, 64'd1);
        tick();
        check("solo_res_valid", {63'd0, res_valid}, 64'd1);
        check("solo_res_id", {63'd0, res_id}, 64'd0);
        check("solo_res_out", res_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("solo_cnt0", {60'd0, grant_cnt0}, 64'd1);
        req0_valid = 1'b0;
        tick();
        check("drain_res_valid", {63'd0, res_valid}, 64'd0);
        check("drain_res_out_hold", res_out, 64'hFFFF_FFFF_FFFF_FFFF);

        // 3: round robin after a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_a = 64'(i + 1);
            req0_b = 64'h0;
            req1_a = 64'h0;
            req1_b = 64'(100 + i);
            settle();
            check("rr_ready0", {63'd0, req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_ready1", {63'd0, req1_ready}, (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            check("rr_res_id", {63'd0, res_id}, (i % 2 == 0) ? 64'd0 : 64'd1);
            check("rr_res_out", res_out, (i % 2 == 0) ? 64'(i + 1) : 64'(100 + i));
        end
        check("rr_cnt0", {60'd0, grant_cnt0}, 64'd3);
        check("rr_cnt1", {60'd0, grant_cnt1}, 64'd3);

        // 4: stall with a full slot, then same-cycle refill
        req1_valid = 1'b0;
        req0_a = 64'h1234_5678_9ABC_DEF0;
        req0_b = 64'h0F0F_0F0F_0F0F_0F0F;
        tick();
        check("stall_load_out", res_out, 64'h1D3B_5977_95B3_D1FF);
        res_ready  = 1'b0;
        req1_valid = 1'b1;
        req0_a = 64'hDEAD_BEEF_0000_0000;
        req1_a = 64'h0123_4567_89AB_CDEF;
        req1_b = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_ready0", {63'd0, req0_ready}, 64'd0);
            check("stall_ready1", {63'd0, req1_ready}, 64'd0);
            tick();
            check("stall_res_valid", {63'd0, res_valid}, 64'd1);
            check("stall_res_out", res_out, 64'h1D3B_5977_95B3_D1FF);
            check("stall_res_id", {63'd0, res_id}, 64'd0);
        end
        res_ready = 1'b1;
        settle();
        check("refill_ready1", {63'd0, req1_ready}, 64'd1);
        check("refill_ready0", {63'd0, req0_ready}, 64'd0);
        tick();
        check("refill_res_valid", {63'd0, res_valid}, 64'd1);
        check("refill_res_id", {63'd0, res_id}, 64'd1);
        check("refill_res_out", res_out, 64'hFEDC_BA98_7654_3210);
        check("refill_cnt0", {60'd0, grant_cnt0}, 64'd4);
        check("refill_cnt1", {60'd0, grant_cnt1}, 64'd4);
        // one more grant to requester 0 leaves the pointer at requester 1
        tick();
        check("pre_rst_res_id", {63'd0, res_id}, 64'd0);

        // 5: reset while full and both requesting
        reset = 1'b1;
        res_ready = 1'b0;
        settle();
        check("rst5_ready0", {63'd0, req0_ready}, 64'd0);
        check("rst5_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        check("rst5_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst5_res_out", res_out, 64'd0);
        check("rst5_cnt0", {60'd0, grant_cnt0}, 64'd0);
        check("rst5_cnt1", {60'd0, grant_cnt1}, 64'd0);
        reset = 1'b0;
        res_ready = 1'b1;
        settle();
        check("rst5_ptr_ready0", {63'd0, req0_ready}, 64'd1);
        check("rst5_ptr_ready1", {63'd0, req1_ready}, 64'd0);

        // 6: counter wrap with CNT_W = 4
        req1_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check("wrap_cnt0_15", {60'd0, grant_cnt0}, 64'd15);
        tick();
        check("wrap_cnt0_0", {60'd0, grant_cnt0}, 64'd0);
        check("wrap_cnt1", {60'd0, grant_cnt1}, 64'd0);
        check("wrap_res_valid", {63'd0, res_valid}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
